// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch / issue path: register geometry,
// the NOP encoding, scheduler states and the decoded-field record.
package fetch_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_W    = 3;

  localparam logic [15:0] NOP = 16'h0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SPLIT = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             wr;
    logic             rd1;
    logic             rd2;
    logic             mem;
    logic             br;
  } dec_t;

  // r0 is hardwired zero, so it can never be the subject of a hazard.
  function automatic logic pend_hit(input logic [NUM_REGS-1:0] pend,
                                    input logic [REG_W-1:0]    r);
    return (r != '0) && pend[r];
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register pending bits with two issue-side set ports, two writeback clear
// ports and read/write hazard queries for two instruction slots.
module reg_scoreboard
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set1_en,
  input  logic [REG_W-1:0] set1_rd,
  input  logic             set2_en,
  input  logic [REG_W-1:0] set2_rd,
  input  logic             clr1_en,
  input  logic [REG_W-1:0] clr1_rd,
  input  logic             clr2_en,
  input  logic [REG_W-1:0] clr2_rd,
  input  logic             qa_valid,
  input  logic [REG_W-1:0] qa_rd,
  input  logic [REG_W-1:0] qa_rs1,
  input  logic [REG_W-1:0] qa_rs2,
  input  logic             qa_wr,
  input  logic             qa_rd1,
  input  logic             qa_rd2,
  input  logic             qb_valid,
  input  logic [REG_W-1:0] qb_rd,
  input  logic [REG_W-1:0] qb_rs1,
  input  logic [REG_W-1:0] qb_rs2,
  input  logic             qb_wr,
  input  logic             qb_rd1,
  input  logic             qb_rd2,
  output logic             hazard_a,
  output logic             hazard_b
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] visible;

  // Writebacks landing this cycle are bypassed into the hazard view, and an
  // issue-side set on the same register overrides the clear.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr1_en) clr_mask[clr1_rd] = 1'b1;
    if (clr2_en) clr_mask[clr2_rd] = 1'b1;
    if (set1_en) set_mask[set1_rd] = 1'b1;
    if (set2_en) set_mask[set2_rd] = 1'b1;
    visible      = pending & ~clr_mask;
    pending_d    = visible | set_mask;
    pending_d[0] = 1'b0;
  end

  assign hazard_a = qa_valid && ((qa_rd1 && pend_hit(visible, qa_rs1)) ||
                                 (qa_rd2 && pend_hit(visible, qa_rs2)) ||
                                 (qa_wr  && pend_hit(visible, qa_rd)));

  assign hazard_b = qb_valid && ((qb_rd1 && pend_hit(visible, qb_rs1)) ||
                                 (qb_rd2 && pend_hit(visible, qb_rs2)) ||
                                 (qb_wr  && pend_hit(visible, qb_rd)));

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_d;
  end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler: pairs fetched instructions against the scoreboard and
// each other, splits conflicting pairs, and sequences branch redirect/flush.
//
// state | meaning
// RUN   | normal pairing of in1/in2
// SPLIT | slot2 parked in hold register, issued alone when hazard-free
// FLUSH | issue suppressed for FLUSH_CYCLES after a redirect
module issue_scheduler
  import fetch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      in1_instr,
  input  logic [REG_W-1:0] in1_rd,
  input  logic [REG_W-1:0] in1_rs1,
  input  logic [REG_W-1:0] in1_rs2,
  input  logic             in1_wr,
  input  logic             in1_rd1,
  input  logic             in1_rd2,
  input  logic             in1_mem,
  input  logic             in1_br,
  input  logic [15:0]      in2_instr,
  input  logic [REG_W-1:0] in2_rd,
  input  logic [REG_W-1:0] in2_rs1,
  input  logic [REG_W-1:0] in2_rs2,
  input  logic             in2_wr,
  input  logic             in2_rd1,
  input  logic             in2_rd2,
  input  logic             in2_mem,
  input  logic             in2_br,
  input  logic             wb1_en,
  input  logic [REG_W-1:0] wb1_rd,
  input  logic             wb2_en,
  input  logic [REG_W-1:0] wb2_rd,
  input  logic             br_resolved,
  input  logic [15:0]      br_target_in,
  output logic             stall,
  output logic             issingleinstr,
  output logic             is_branch_taken,
  output logic [15:0]      branch_target,
  output logic             iss1_valid,
  output logic             iss2_valid,
  output logic [15:0]      iss1_instr,
  output logic [15:0]      iss2_instr
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [15:0]      hold_instr;
  dec_t             hold_dec;
  dec_t             in1_dec, in2_dec, slot1_dec;
  logic [15:0]      slot1_instr;
  logic             slot1_valid, slot2_valid;
  logic             haz1, haz2;
  logic             pair_raw, pair_waw, pair_mem, pair_br;
  logic             issue1, issue2, hold_load, hold_clear;

  assign in1_dec = '{rd: in1_rd, rs1: in1_rs1, rs2: in1_rs2, wr: in1_wr,
                     rd1: in1_rd1, rd2: in1_rd2, mem: in1_mem, br: in1_br};
  assign in2_dec = '{rd: in2_rd, rs1: in2_rs1, rs2: in2_rs2, wr: in2_wr,
                     rd1: in2_rd1, rd2: in2_rd2, mem: in2_mem, br: in2_br};

  // In SPLIT the parked instruction takes slot1 and slot2 is ignored.
  assign slot1_instr = (state == SPLIT) ? hold_instr : in1_instr;
  assign slot1_dec   = (state == SPLIT) ? hold_dec   : in1_dec;
  assign slot1_valid = (slot1_instr != NOP);
  assign slot2_valid = (state == RUN) && (in2_instr != NOP);

  assign pair_raw = slot1_valid && slot1_dec.wr && (slot1_dec.rd != '0) &&
                    ((in2_dec.rd1 && (in2_dec.rs1 == slot1_dec.rd)) ||
                     (in2_dec.rd2 && (in2_dec.rs2 == slot1_dec.rd)));
  assign pair_waw = slot1_valid && slot1_dec.wr && in2_dec.wr &&
                    (slot1_dec.rd != '0) && (in2_dec.rd == slot1_dec.rd);
  assign pair_mem = slot1_valid && slot1_dec.mem && in2_dec.mem;
  assign pair_br  = slot1_valid && slot1_dec.br;

  reg_scoreboard u_sb (
    .clk      (clk),
    .reset    (reset),
    .set1_en  (issue1 && slot1_dec.wr && (slot1_dec.rd != '0)),
    .set1_rd  (slot1_dec.rd),
    .set2_en  (issue2 && in2_dec.wr && (in2_dec.rd != '0)),
    .set2_rd  (in2_dec.rd),
    .clr1_en  (wb1_en),
    .clr1_rd  (wb1_rd),
    .clr2_en  (wb2_en),
    .clr2_rd  (wb2_rd),
    .qa_valid (slot1_valid),
    .qa_rd    (slot1_dec.rd),
    .qa_rs1   (slot1_dec.rs1),
    .qa_rs2   (slot1_dec.rs2),
    .qa_wr    (slot1_dec.wr),
    .qa_rd1   (slot1_dec.rd1),
    .qa_rd2   (slot1_dec.rd2),
    .qb_valid (slot2_valid),
    .qb_rd    (in2_dec.rd),
    .qb_rs1   (in2_dec.rs1),
    .qb_rs2   (in2_dec.rs2),
    .qb_wr    (in2_dec.wr),
    .qb_rd1   (in2_dec.rd1),
    .qb_rd2   (in2_dec.rd2),
    .hazard_a (haz1),
    .hazard_b (haz2)
  );

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    stall      = 1'b0;
    issue1     = 1'b0;
    issue2     = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    if (br_resolved) begin
      state_d    = FLUSH;
      cnt_d      = CNT_W'(FLUSH_CYCLES);
      hold_clear = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (haz1) begin
            stall = 1'b1;
          end else begin
            issue1 = slot1_valid;
            if (slot2_valid) begin
              if (!haz2 && !pair_raw && !pair_waw && !pair_mem && !pair_br) begin
                issue2 = 1'b1;
              end else begin
                hold_load = 1'b1;
                state_d   = SPLIT;
                stall     = 1'b1;
              end
            end
          end
        end
        SPLIT: begin
          stall = 1'b1;
          if (!haz1) begin
            issue1     = slot1_valid;
            hold_clear = 1'b1;
            state_d    = RUN;
          end
        end
        FLUSH: begin
          if (cnt <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RUN;
      cnt             <= '0;
      hold_instr      <= NOP;
      hold_dec        <= '0;
      iss1_valid      <= 1'b0;
      iss2_valid      <= 1'b0;
      iss1_instr      <= NOP;
      iss2_instr      <= NOP;
      issingleinstr   <= 1'b0;
      is_branch_taken <= 1'b0;
      branch_target   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (hold_clear) begin
        hold_instr <= NOP;
        hold_dec   <= '0;
      end else if (hold_load) begin
        hold_instr <= in2_instr;
        hold_dec   <= in2_dec;
      end
      iss1_valid      <= issue1;
      iss2_valid      <= issue2;
      iss1_instr      <= issue1 ? slot1_instr : NOP;
      iss2_instr      <= issue2 ? in2_instr : NOP;
      issingleinstr   <= (state_d == SPLIT);
      is_branch_taken <= br_resolved;
      if (br_resolved) branch_target <= br_target_in;
    end
  end

endmodule
